// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the pc_seq_unit fetch-address sequencer.
// Optional alignment checking is enabled with the PC_ALIGN_CHECK_EN macro.
package pc_seq_pkg;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT = 2'd0;
    localparam pc_state_t ST_RUN  = 2'd1;
    localparam pc_state_t ST_HALT = 2'd2;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_EXC
    } pc_src_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;

    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_EXC) || (src == SRC_JUMP) || (src == SRC_BRANCH);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for pc_seq_unit.
// With PC_ALIGN_CHECK_EN, misaligned jump/branch targets divert to the exception vector.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                WIDTH      = 32,
`ifdef PC_ALIGN_CHECK_EN
    parameter int                STEP       = 4,
`endif
    parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(PC_EXC_VECTOR)
) (
    input  pc_state_t           state_i,
    input  logic [WIDTH-1:0]    pc_i,
    input  logic [WIDTH-1:0]    pc_seq_i,
    input  logic                stall_i,
    input  logic                halt_req_i,
    input  logic                exc_req_i,
    input  logic                jump_i,
    input  logic [WIDTH-1:0]    jump_target_i,
    input  logic                branch_taken_i,
    input  logic [WIDTH-1:0]    branch_target_i,
`ifdef PC_ALIGN_CHECK_EN
    output logic                misalign_o,
`endif
    output pc_src_e             src_o,
    output logic [WIDTH-1:0]    next_pc_o
);

    pc_src_e raw_src;

    // BOOT ignores every input; HALT only reacts to an exception.
    always_comb begin
        raw_src = SRC_HOLD;
        if (state_i == ST_RUN) begin
            if (exc_req_i)                 raw_src = SRC_EXC;
            else if (jump_i)               raw_src = SRC_JUMP;
            else if (branch_taken_i)       raw_src = SRC_BRANCH;
            else if (stall_i || halt_req_i) raw_src = SRC_HOLD;
            else                           raw_src = SRC_SEQ;
        end else if (state_i == ST_HALT && exc_req_i) begin
            raw_src = SRC_EXC;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic target_misaligned;

    always_comb begin
        target_misaligned = 1'b0;
        if (raw_src == SRC_JUMP)
            target_misaligned = |(jump_target_i & ALIGN_MASK);
        else if (raw_src == SRC_BRANCH)
            target_misaligned = |(branch_target_i & ALIGN_MASK);
    end

    assign src_o      = target_misaligned ? SRC_EXC : raw_src;
    assign misalign_o = target_misaligned;
`else
    assign src_o = raw_src;
`endif

    always_comb begin
        next_pc_o = pc_i;
        case (src_o)
            SRC_EXC:    next_pc_o = EXC_VECTOR;
            SRC_JUMP:   next_pc_o = jump_target_i;
            SRC_BRANCH: next_pc_o = branch_target_i;
            SRC_SEQ:    next_pc_o = pc_seq_i;
            default:    next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: architectural PC, BOOT/RUN/HALT control and redirect selection.
// Define PC_ALIGN_CHECK_EN to add the misalign output and target alignment checking.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                resume,
    input  logic                exc_req,
    input  logic                jump,
    input  logic [WIDTH-1:0]    jump_target,
    input  logic                branch_taken,
    input  logic [WIDTH-1:0]    branch_target,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_seq,
    output logic                fetch_valid,
    output logic                redirect,
`ifdef PC_ALIGN_CHECK_EN
    output logic                misalign,
`endif
    output logic                halted
);

    pc_state_t          state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               fetch_valid_q;
    logic               redirect_q;
    pc_src_e            src;

    assign pc_seq = pc_q + WIDTH'(STEP);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_d, misalign_q;
`endif

    pc_next_sel #(
        .WIDTH      (WIDTH),
`ifdef PC_ALIGN_CHECK_EN
        .STEP       (STEP),
`endif
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .pc_seq_i        (pc_seq),
        .stall_i         (stall),
        .halt_req_i      (halt_req),
        .exc_req_i       (exc_req),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o      (misalign_d),
`endif
        .src_o           (src),
        .next_pc_o       (pc_d)
    );

    // A redirect or stall pre-empts halt_req, so HALT is entered only from a plain hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (src == SRC_HOLD && !stall && halt_req) state_d = ST_HALT;
            ST_HALT: if (src == SRC_EXC || resume) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= (state_d == ST_RUN);
            redirect_q    <= is_redirect(src);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`endif

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign redirect    = redirect_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized traffic against a reference model.
// Follows the DUT build: define PC_ALIGN_CHECK_EN for both when checking the alignment feature.
module tb_pc_seq_unit;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] EXV = 32'h8000_0180;

    logic        clk;
    logic        rst_n;
    logic        stall, halt_req, resume, exc_req, jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic [31:0] pc, pc_seq;
    logic        fetch_valid, redirect, halted;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int testCount = 0;
    int failCount = 0;

    // Reference model state: mode 0 = boot, 1 = run, 2 = halt
    int          mMode;
    logic [31:0] mPc;
    bit          mFv, mRed, mMis;

    pc_seq_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .exc_req       (exc_req),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_seq        (pc_seq),
        .fetch_valid   (fetch_valid),
        .redirect      (redirect),
`ifdef PC_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %h, required %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mMode = 0;
        mPc   = RV;
        mFv   = 1'b0;
        mRed  = 1'b0;
        mMis  = 1'b0;
    endfunction

    // One clock edge of the sequencer described at the architectural level.
    function automatic void modelStep();
        logic [31:0] tgt;
        mRed = 1'b0;
        mMis = 1'b0;
        if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 1) begin
            if (exc_req) begin
                mPc  = EXV;
                mRed = 1'b1;
            end else if (jump || branch_taken) begin
                tgt  = jump ? jump_target : branch_target;
                mRed = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    mPc  = EXV;
                    mMis = 1'b1;
                end else begin
                    mPc = tgt;
                end
`else
                mPc = tgt;
`endif
            end else if (stall) begin
                mPc = mPc;
            end else if (halt_req) begin
                mMode = 2;
            end else begin
                mPc = mPc + 4;
            end
        end else begin
            if (exc_req) begin
                mPc   = EXV;
                mRed  = 1'b1;
                mMode = 1;
            end else if (resume) begin
                mMode = 1;
            end
        end
        mFv = (mMode == 1);
    endfunction

    task automatic checkAll(input string where);
        checkOutput({where, ".pc"},          pc,                      mPc);
        checkOutput({where, ".pc_seq"},      pc_seq,                  mPc + 32'd4);
        checkOutput({where, ".fetch_valid"}, {31'd0, fetch_valid},    {31'd0, mFv});
        checkOutput({where, ".redirect"},    {31'd0, redirect},       {31'd0, mRed});
        checkOutput({where, ".halted"},      {31'd0, halted},         {31'd0, (mMode == 2)});
`ifdef PC_ALIGN_CHECK_EN
        checkOutput({where, ".misalign"},    {31'd0, misalign},       {31'd0, mMis});
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input string where,
                                 input logic s, input logic h, input logic r, input logic e,
                                 input logic j, input logic [31:0] jt,
                                 input logic b, input logic [31:0] bt);
        stall = s; halt_req = h; resume = r; exc_req = e;
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        @(posedge clk);
        #1;
        modelStep();
        checkAll(where);
    endtask

    task automatic idle(input string where);
        applyStimulus(where, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, then released after an edge.
    task automatic doReset(input string where);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll({where, ".async"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkAll({where, ".boot"});
    endtask

    initial begin
        logic s, h, r, e, j, b;
        logic [31:0] jt, bt;

        rst_n = 1'b0;
        stall = 0; halt_req = 0; resume = 0; exc_req = 0;
        jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst_n = 1'b1;
        checkAll("boot");

        idle("idle1"); checkOutput("idle1.spec_pc", pc, 32'hBFC0_0000);
        idle("idle2"); checkOutput("idle2.spec_pc", pc, 32'hBFC0_0004);
        idle("idle3"); checkOutput("idle3.spec_pc", pc, 32'hBFC0_0008);
        idle("idle4");
        idle("idle5"); checkOutput("idle5.spec_pc", pc, 32'hBFC0_0010);

        applyStimulus("stall_br", 1, 0, 0, 0, 0, 32'h0, 1, 32'hBFC0_0100);
        checkOutput("stall_br.spec_pc", pc, 32'hBFC0_0100);
        checkOutput("stall_br.spec_red", {31'd0, redirect}, 32'd1);
        idle("after_br");
        checkOutput("after_br.spec_red", {31'd0, redirect}, 32'd0);

        applyStimulus("exc_all", 0, 0, 0, 1, 1, 32'h1234_5678, 1, 32'h8765_4320);
        checkOutput("exc_all.spec_pc", pc, 32'h8000_0180);
        applyStimulus("stall1", 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus("stall2", 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("stall2.spec_pc", pc, 32'h8000_0180);

        applyStimulus("jmp20", 0, 0, 0, 0, 1, 32'hBFC0_0020, 0, 32'h0);
        applyStimulus("halt", 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("halt.spec_halted", {31'd0, halted}, 32'd1);
        applyStimulus("halt_ign1", 1, 0, 0, 0, 1, 32'h0000_4000, 0, 32'h0);
        applyStimulus("halt_ign2", 0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_5000);
        applyStimulus("halt_ign3", 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus("resume", 0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("resume.spec_pc", pc, 32'hBFC0_0020);
        idle("post_resume");
        checkOutput("post_resume.spec_pc", pc, 32'hBFC0_0024);

        applyStimulus("halt_redir", 0, 1, 0, 0, 0, 32'h0, 1, 32'hBFC0_0040);
        checkOutput("halt_redir.spec_halted", {31'd0, halted}, 32'd0);

        applyStimulus("jmp_top", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        checkOutput("jmp_top.spec_seq", pc_seq, 32'h0000_0000);
        idle("wrap1"); checkOutput("wrap1.spec_pc", pc, 32'h0000_0000);
        idle("wrap2"); checkOutput("wrap2.spec_pc", pc, 32'h0000_0004);

        applyStimulus("br_misal", 0, 0, 0, 0, 0, 32'h0, 1, 32'hBFC0_0102);
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("br_misal.spec_pc", pc, 32'h8000_0180);
        checkOutput("br_misal.spec_mis", {31'd0, misalign}, 32'd1);
        applyStimulus("exc_halt", 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus("exc_in_halt", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("exc_in_halt.spec_pc", pc, 32'h8000_0180);
`else
        checkOutput("br_misal.spec_pc", pc, 32'hBFC0_0102);
`endif

        applyStimulus("halt_rst", 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        doReset("rst_halt");
        checkOutput("rst_halt.spec_pc", pc, 32'hBFC0_0000);
        checkOutput("rst_halt.spec_halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 19) == 0);
            j  = ($urandom_range(0, 9) == 0);
            b  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 4) == 0);
            h  = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 3) == 0);
            jt = $urandom();
            bt = $urandom();
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            applyStimulus("rand", s, h, r, e, j, jt, b, bt);
            if ($urandom_range(0, 99) == 0) doReset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
